// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the multi-word carry-skip sequencer.
// Imported by the sequencer top and its adder datapath.
package csa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 16;

endpackage

// File: rtl/carry_skip_adder_32bit.sv
// 32-bit carry-skip adder built from 4-bit ripple blocks.
// A block whose bits all propagate forwards its incoming carry directly.
module carry_skip_adder_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int BLK = 4;
    localparam int NB  = 32 / BLK;

    logic [31:0] w_p;
    logic [31:0] w_g;

    assign w_p = A ^ B;
    assign w_g = A & B;

    // Ripple inside each block, skip the block when it fully propagates.
    always_comb begin
        logic cb;
        logic rc;
        sum = '0;
        cb  = cin;
        rc  = 1'b0;
        for (int k = 0; k < NB; k++) begin
            rc = cb;
            for (int j = 0; j < BLK; j++) begin
                sum[k*BLK+j] = w_p[k*BLK+j] ^ rc;
                rc = w_g[k*BLK+j] | (w_p[k*BLK+j] & rc);
            end
            cb = (&w_p[k*BLK +: BLK]) ? cb : rc;
        end
        cout = cb;
    end

endmodule

// File: rtl/csa_multiword_add_seq.sv
// Multi-word add/subtract that reuses one 32-bit carry-skip adder,
// processing one word per cycle, least significant word first.
module csa_multiword_add_seq
    import csa_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [WORD_W-1:0]   r_a   [WORDS];
    logic [WORD_W-1:0]   r_b   [WORDS];
    logic [WORD_W-1:0]   r_sum [WORDS];
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;

    logic [WORD_W-1:0]   w_a_word;
    logic [WORD_W-1:0]   w_b_word;
    logic [WORD_W-1:0]   w_sum;
    logic                w_cout;

    assign w_a_word = r_a[r_idx];
    assign w_b_word = r_b[r_idx];

    carry_skip_adder_32bit u_adder (
        .A    (w_a_word),
        .B    (w_b_word),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept in IDLE, step words in RUN, hold in DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (r_idx == LAST) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, per-word result write-back and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_sum[i] <= '0;
            end
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < WORDS; i++) begin
                            r_a[i] <= a[i*WORD_W +: WORD_W];
                            r_b[i] <= sub ? ~b[i*WORD_W +: WORD_W]
                                          :  b[i*WORD_W +: WORD_W];
                        end
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= w_sum;
                    r_carry      <= w_cout;
                    if (r_idx != LAST) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Flatten the word array onto the result bus.
    always_comb begin
        sum = '0;
        for (int i = 0; i < WORDS; i++) begin
            sum[i*WORD_W +: WORD_W] = r_sum[i];
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN);
    assign cout      = r_carry;
    assign ovf       = (r_a[WORDS-1][WORD_W-1] == r_b[WORDS-1][WORD_W-1])
                    && (r_sum[WORDS-1][WORD_W-1] != r_a[WORDS-1][WORD_W-1]);

endmodule

// File: tb/tb_csa_multiword_add_seq.sv
// Scoreboard bench for the multi-word sequencer: 4-word and 1-word builds
// checked against a plain-arithmetic reference model.
module tb_csa_multiword_add_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         iv4, ir4, cin4, sub4, ov4, or4, co4, of4, bz4;
    logic [127:0] a4, b4, s4;
    logic         iv1, ir1, cin1, sub1, ov1, or1, co1, of1, bz1;
    logic [31:0]  a1, b1, s1;

    csa_multiword_add_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .ovf(of4), .busy(bz4)
    );

    csa_multiword_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(ov1), .out_ready(or1),
        .sum(s1), .cout(co1), .ovf(of1), .busy(bz1)
    );

    typedef struct {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   seen4 = 1'b0;
    bit   seen1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: w-bit unsigned/signed arithmetic on wide integers.
    function automatic exp_t model(int w, logic [127:0] a, logic [127:0] b,
                                   logic cin, logic sub, int acc);
        logic [128:0] m;
        logic [128:0] aa;
        logic [128:0] bb;
        logic [128:0] full;
        logic         sa, sb, sr;
        exp_t         e;
        m  = (129'd1 << w) - 129'd1;
        aa = {1'b0, a} & m;
        bb = {1'b0, b} & m;
        if (sub) begin
            full   = (aa - bb) & m;
            e.cout = (aa >= bb);
        end else begin
            full   = aa + bb + {128'd0, cin};
            e.cout = full[w];
        end
        e.sum = full[127:0] & m[127:0];
        sa = aa[w-1];
        sb = bb[w-1];
        sr = full[w-1];
        e.ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        e.acc = acc;
        return e;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected expected handshake", nm);
    endtask

    // Monitor for the 4-word build.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen4 = 1'b0;
        end else if (ov4) begin
            if (q4.size() == 0) begin
                fail_now("unexpected_out_valid4");
            end else begin
                if (!seen4) begin
                    chk("latency4", 128'(cyc - q4[0].acc), 128'd4);
                    seen4 = 1'b1;
                end
                chk("sum4", s4, q4[0].sum);
                chk("cout4", {127'd0, co4}, {127'd0, q4[0].cout});
                chk("ovf4", {127'd0, of4}, {127'd0, q4[0].ovf});
                chk("in_ready_done4", {127'd0, ir4}, 128'd0);
                chk("busy_done4", {127'd0, bz4}, 128'd0);
                if (or4) begin
                    void'(q4.pop_front());
                    seen4 = 1'b0;
                end
            end
        end
    end

    // Monitor for the 1-word build.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen1 = 1'b0;
        end else if (ov1) begin
            if (q1.size() == 0) begin
                fail_now("unexpected_out_valid1");
            end else begin
                if (!seen1) begin
                    chk("latency1", 128'(cyc - q1[0].acc), 128'd1);
                    seen1 = 1'b1;
                end
                chk("sum1", {96'd0, s1}, q1[0].sum);
                chk("cout1", {127'd0, co1}, {127'd0, q1[0].cout});
                chk("ovf1", {127'd0, of1}, {127'd0, q1[0].ovf});
                if (or1) begin
                    void'(q1.pop_front());
                    seen1 = 1'b0;
                end
            end
        end
    end

    // Present one request and wait (bounded) for it to be accepted.
    task automatic issue(int w, logic [127:0] a, logic [127:0] b,
                         logic cin, logic sub, bit push);
        bit ok;
        ok = 1'b0;
        if (w == 4) begin
            a4 = a; b4 = b; cin4 = cin; sub4 = sub; iv4 = 1'b1;
        end else begin
            a1 = a[31:0]; b1 = b[31:0]; cin1 = cin; sub1 = sub; iv1 = 1'b1;
        end
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if ((w == 4) ? ir4 : ir1) ok = 1'b1;
        end
        if (!ok) begin
            fail_now("accept_timeout");
        end else if (push) begin
            if (w == 4) q4.push_back(model(128, a, b, cin, sub, cyc + 1));
            else        q1.push_back(model(32, a, b, cin, sub, cyc + 1));
        end
        @(posedge clk);
        #1;
        if (w == 4) iv4 = 1'b0;
        else        iv1 = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && (q4.size() != 0 || q1.size() != 0); t++)
            @(negedge clk);
        if (q4.size() != 0 || q1.size() != 0) fail_now("drain_timeout");
    endtask

    function automatic logic [127:0] r128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] ones;
        logic [127:0] maxpos;
        bit           got;
        ones   = '1;
        maxpos = {1'b0, {127{1'b1}}};
        iv4 = 0; cin4 = 0; sub4 = 0; a4 = '0; b4 = '0; or4 = 1'b1;
        iv1 = 0; cin1 = 0; sub1 = 0; a1 = '0; b1 = '0; or1 = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (10) begin
            @(negedge clk);
            chk("rst_in_ready4", {127'd0, ir4}, 128'd1);
            chk("rst_out_valid4", {127'd0, ov4}, 128'd0);
            chk("rst_sum4", s4, 128'd0);
            chk("rst_cout4", {127'd0, co4}, 128'd0);
            chk("rst_ovf4", {127'd0, of4}, 128'd0);
            chk("rst_busy4", {127'd0, bz4}, 128'd0);
            chk("rst_in_ready1", {127'd0, ir1}, 128'd1);
            chk("rst_sum1", {96'd0, s1}, 128'd0);
        end

        @(posedge clk); #1;
        issue(4, ones, 128'd0, 1'b1, 1'b0, 1'b1);
        issue(4, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1,
              1'b0, 1'b0, 1'b1);
        issue(4, 128'd0, 128'd1, 1'b0, 1'b1, 1'b1);
        issue(4, maxpos, ones, 1'b0, 1'b1, 1'b1);
        issue(4, maxpos, 128'd1, 1'b0, 1'b0, 1'b1);
        issue(4, 128'd5, 128'd5, 1'b1, 1'b1, 1'b1);
        drain();

        or4 = 1'b0;
        @(posedge clk); #1;
        issue(4, r128(), r128(), 1'b1, 1'b0, 1'b1);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (ov4) got = 1'b1;
        end
        if (!got) fail_now("bp_out_valid_timeout");
        @(posedge clk); #1;
        a4 = r128(); b4 = r128(); iv4 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        iv4 = 1'b0;
        or4 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", {127'd0, ir4}, 128'd1);
        drain();

        @(posedge clk); #1;
        for (int n = 0; n < 12; n++) begin
            issue(4, r128(), r128(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        @(posedge clk); #1;
        issue(4, r128(), r128(), 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("mid_busy4", {127'd0, bz4}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_in_ready4", {127'd0, ir4}, 128'd1);
        chk("mid_out_valid4", {127'd0, ov4}, 128'd0);
        chk("mid_busy_after4", {127'd0, bz4}, 128'd0);
        chk("mid_sum4", s4, 128'd0);
        chk("mid_cout4", {127'd0, co4}, 128'd0);
        chk("mid_ovf4", {127'd0, of4}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_no_result4", {127'd0, ov4}, 128'd0);

        @(posedge clk); #1;
        issue(1, 128'hDEAD_BEEF, 128'h0102_0304, 1'b0, 1'b0, 1'b1);
        issue(1, 128'h7FFF_FFFF, 128'h1, 1'b0, 1'b0, 1'b1);
        issue(1, 128'h0, 128'h1, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 8; n++) begin
            issue(1, {96'd0, $urandom()}, {96'd0, $urandom()},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_multiword_add_seq.md
# csa_multiword_add_seq

Sequencer that time-shares one `carry_skip_adder_32bit` instance to perform WORDS×32-bit add or subtract, one 32-bit word per cycle, LSW first, with the carry chained through a register. It sits between a valid/ready producer (operand source) and a valid/ready consumer. It gives wide-precision arithmetic without replicating the adder.

## Interface
Parameters:
- `WORDS`, default 4: number of 32-bit words per operand; legal range 1..16; operand width W = 32*WORDS.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand request valid
- `in_ready`  out  1  block can accept a request
- `a`  in  W  operand A
- `b`  in  W  operand B
- `cin`  in  1  carry-in; ignored when `sub`=1
- `sub`  in  1  0: A+B+cin; 1: A−B, computed as A+~B+1
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `sum`  out  W  result, modulo 2^W
- `cout`  out  1  carry out of bit W−1; for `sub`=1 this is 1 when there is no borrow (A≥B unsigned)
- `ovf`  out  1  signed two's-complement overflow of the W-bit operation
- `busy`  out  1  high in RUN

## Operation
- FSM states IDLE, RUN, DONE, encoded as 2 bits.
- IDLE: `in_ready`=1. When `in_valid` is high:
  - Latch `a` into a_r and latch `b` into b_r. If `sub`=1, latch ~`b`.
  - Set carry_r = `sub` ? 1 : `cin`.
  - Set idx = 0 and go to RUN.
- RUN: `in_ready`=0 and `busy`=1. Each cycle:
  - Drive the adder with word idx of a_r, word idx of b_r, and carry_r.
  - On the clock edge, write the adder sum into `sum` word idx and set carry_r = adder cout.
  - If idx == WORDS−1, go to DONE. Otherwise increment idx.
- DONE: `out_valid`=1, and `sum`, `cout`, `ovf` are held stable. Return to IDLE when `out_ready` is high.
- Final values:
  - `cout` = final carry_r.
  - `ovf` = (a_r[W−1] == b_r[W−1]) && (`sum`[W−1] != a_r[W−1]). b_r here is the already-inverted operand.
- While `out_valid`=1, the `sum`, `cout` and `ovf` outputs must not change, even if `in_valid` toggles.
- New requests are accepted only in IDLE; there is no overlap.
- idx counter width is ceil(log2(WORDS)), with a minimum of 1. For WORDS=1, RUN lasts exactly one cycle.
- `sum` is undefined while RUN is in progress. Internally it holds stale and partial words, which the bench must not check.

## Timing
- Reset (async assert, synchronous-safe release):
  - State = IDLE; `in_ready`=1.
  - `out_valid`=0, `busy`=0.
  - `sum`=0, `cout`=0, `ovf`=0, carry_r=0, idx=0.
  - a_r=0, b_r=0.
- Reset asserted mid-RUN or in DONE aborts the operation. The result is lost and never presented.
- Request accepted on edge E0 (`in_valid`&&`in_ready`). RUN occupies the cycles after E0 through edge E0+WORDS. `out_valid` is high from edge E0+WORDS.
- Latency from acceptance to `out_valid` is WORDS cycles.
- Handshake completes on the first edge where `out_valid`&&`out_ready`. `in_ready` is high in the following cycle.
- Peak throughput is one operation per WORDS+2 cycles (one IDLE cycle is mandatory between operations).
- `out_ready` held high in advance has the effect that DONE lasts exactly one cycle.
- The combinational adder path is a_r/b_r word mux → adder → sum/carry registers. There is no combinational path from inputs to outputs.

## Structure
- Shared package `csa_seq_pkg` contains:
  - the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the word width constant WORD_W=32
  - the maximum WORDS limit of 16
- Exactly one sub-module: the existing `carry_skip_adder_32bit`, instantiated once with ports A, B, cin, sum, cout. The word muxing lives in this block.

## Test plan
Use WORDS=4 unless noted.
- Reset then idle: after `rst_n` release, expect `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0. With `in_valid`=0 for 10 cycles, all outputs stay unchanged.
- Full carry ripple across words: a=2^128−1, b=0, cin=1, sub=0. Expect `out_valid` exactly 4 cycles after acceptance, `sum`=0, `cout`=1, `ovf`=0.
- Cross-word carry: a=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, b=1, cin=0. Expect `sum`=0x…0001_0000_0000_0000_0000, `cout`=0.
- Subtract with borrow and signed overflow:
  - a=0, b=1, sub=1: expect `sum`=all ones, `cout`=0, `ovf`=0.
  - a=0x7FFF…FF, b=0xFFFF…FF (−1), sub=1: expect `sum`=0x8000…00, `ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. Expect `sum`, `cout` and `ovf` stable, `in_ready`=0, and a concurrent `in_valid` ignored. Release `out_ready`; expect `in_ready`=1 on the next cycle.
- Mid-operation reset and WORDS=1:
  - Assert `rst_n`=0 in the second RUN cycle. Expect all outputs at reset values immediately, and no `out_valid` afterwards.
  - Separately, with WORDS=1: a=0xDEADBEEF, b=0x01020304. Expect `sum`=0xDFAFC1F3 with 1-cycle latency.
